// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
// Provides the per-channel FSM state type and the down-counter width function.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_OFF   = 2'd0,
        CG_WAKE  = 2'd1,
        CG_ON    = 2'd2,
        CG_DRAIN = 2'd3
    } cg_state_e;

    // Width of the per-channel wake/idle down-counter, never below one bit
    function automatic int cg_cnt_w(input int wake, input int idle);
        int m;
        m = (wake > idle) ? wake : idle;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free latch-based integrated clock gate with asynchronous latch clear.
// The enable is captured only while CLK is low, so ENCLK pulses are always full high phases.
module clk_gate_cell (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic TE,
    output logic ENCLK
);

    logic r_en_l;

    // Enable latch: transparent in the low phase, cleared by reset unless test mode holds it open
    always_latch begin
        if (RST && !TE) begin
            r_en_l <= 1'b0;
        end else if (!CLK) begin
            r_en_l <= EN | TE;
        end
    end

    assign ENCLK = CLK & r_en_l;

    a_enclk_and : assert property (
        @(negedge CLK) disable iff (RST)
        ENCLK == (CLK & r_en_l)
    );

    a_rise_en : assert property (
        @(posedge ENCLK) r_en_l
    );

endmodule

// File: rtl/clock_gate_ctrl_multi.sv
// Multi-channel auto clock-gating controller: per-channel request FSM, wake settle, idle drain.
// Optional gated-cycle statistics counters are built when CLK_GATE_STATS_EN is defined.
module clock_gate_ctrl_multi
    import clk_gate_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8
`ifdef CLK_GATE_STATS_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TE,
    input  logic [N_CH-1:0]       REQ,
    output logic [N_CH-1:0]       ACK,
    output logic [N_CH-1:0]       GATE_ON,
    output logic [N_CH-1:0]       ENCLK
`ifdef CLK_GATE_STATS_EN
    ,
    input  logic                  CLR_STATS,
    output logic [N_CH*CNT_W-1:0] GATED_CNT
`endif
);

    localparam int CW = cg_cnt_w(WAKE_CYCLES, IDLE_CYCLES);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LD =
        (IDLE_CYCLES > 0) ? CW'(IDLE_CYCLES - 1) : '0;

    cg_state_e       r_state  [N_CH];
    cg_state_e       w_state_nx [N_CH];
    logic [CW-1:0]   r_cnt    [N_CH];
    logic [CW-1:0]   w_cnt_nx [N_CH];
    logic [N_CH-1:0] r_en_q;
    logic [N_CH-1:0] w_en_nx;
    logic [N_CH-1:0] r_ack;
    logic [N_CH-1:0] w_ack_nx;

    // Next-state logic for every channel; each channel sees only its own REQ bit
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_state_nx[c] = r_state[c];
            w_cnt_nx[c]   = r_cnt[c];
            w_en_nx[c]    = r_en_q[c];
            w_ack_nx[c]   = r_ack[c];
            unique case (r_state[c])
                CG_OFF: begin
                    if (REQ[c]) begin
                        w_state_nx[c] = CG_WAKE;
                        w_en_nx[c]    = 1'b1;
                        w_cnt_nx[c]   = WAKE_LD;
                    end
                end
                CG_WAKE: begin
                    // A dropped request does not abort the wake sequence
                    if (r_cnt[c] != '0) begin
                        w_cnt_nx[c] = r_cnt[c] - C_ONE;
                    end else begin
                        w_state_nx[c] = CG_ON;
                        w_ack_nx[c]   = 1'b1;
                    end
                end
                CG_ON: begin
                    if (!REQ[c]) begin
                        if (IDLE_CYCLES == 0) begin
                            w_state_nx[c] = CG_OFF;
                            w_en_nx[c]    = 1'b0;
                            w_ack_nx[c]   = 1'b0;
                        end else begin
                            w_state_nx[c] = CG_DRAIN;
                            w_cnt_nx[c]   = IDLE_LD;
                        end
                    end
                end
                CG_DRAIN: begin
                    if (REQ[c]) begin
                        w_state_nx[c] = CG_ON;
                    end else if (r_cnt[c] != '0) begin
                        w_cnt_nx[c] = r_cnt[c] - C_ONE;
                    end else begin
                        w_state_nx[c] = CG_OFF;
                        w_en_nx[c]    = 1'b0;
                        w_ack_nx[c]   = 1'b0;
                    end
                end
                default: begin
                    w_state_nx[c] = CG_OFF;
                    w_en_nx[c]    = 1'b0;
                    w_ack_nx[c]   = 1'b0;
                    w_cnt_nx[c]   = '0;
                end
            endcase
        end
    end

    // State, counter, enable and acknowledge registers for all channels
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= CG_OFF;
                r_cnt[c]   <= '0;
            end
            r_en_q <= '0;
            r_ack  <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= w_state_nx[c];
                r_cnt[c]   <= w_cnt_nx[c];
            end
            r_en_q <= w_en_nx;
            r_ack  <= w_ack_nx;
        end
    end

    assign ACK     = r_ack;
    assign GATE_ON = r_en_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_gate_cell u_cell (
            .CLK   (CLK),
            .RST   (RST),
            .EN    (r_en_q[g]),
            .TE    (TE),
            .ENCLK (ENCLK[g])
        );

        a_ack_state : assert property (
            @(posedge CLK) disable iff (RST)
            r_ack[g] |-> (r_state[g] == CG_ON || r_state[g] == CG_DRAIN)
        );
    end

`ifdef CLK_GATE_STATS_EN
    logic [CNT_W-1:0] r_gcnt [N_CH];

    // Count functional cycles spent gated; clear beats increment, value saturates
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < N_CH; c++) begin
                r_gcnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (CLR_STATS) begin
                    r_gcnt[c] <= '0;
                end else if (!r_en_q[c] && !TE && (r_gcnt[c] != '1)) begin
                    r_gcnt[c] <= r_gcnt[c] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_stat
        assign GATED_CNT[g*CNT_W +: CNT_W] = r_gcnt[g];
    end
`endif

endmodule
